// File: rtl/xil_sp_arbiter_if.sv
// rtl/xil_sp_arbiter_if.sv - two requester ports plus the single-port RAM side of the arbiter
interface xil_sp_arbiter_if #(
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 11
);
  localparam int DW = NB_COL * COL_WIDTH;

  logic                  req_0_i;
  logic                  gnt_0_o;
  logic [ADDR_WIDTH-1:0] addr_0_i;
  logic                  we_0_i;
  logic [NB_COL-1:0]     be_0_i;
  logic [DW-1:0]         wdata_0_i;
  logic                  rvalid_0_o;
  logic [DW-1:0]         rdata_0_o;

  logic                  req_1_i;
  logic                  gnt_1_o;
  logic [ADDR_WIDTH-1:0] addr_1_i;
  logic                  we_1_i;
  logic [NB_COL-1:0]     be_1_i;
  logic [DW-1:0]         wdata_1_i;
  logic                  rvalid_1_o;
  logic [DW-1:0]         rdata_1_o;

  logic                  mem_ena_o;
  logic [NB_COL-1:0]     mem_wea_o;
  logic [ADDR_WIDTH-1:0] mem_addra_o;
  logic [DW-1:0]         mem_dina_o;
  logic [DW-1:0]         mem_douta_i;
  logic                  mem_regcea_o;
  logic                  mem_rsta_o;

  modport slave (
    input  req_0_i, addr_0_i, we_0_i, be_0_i, wdata_0_i,
    input  req_1_i, addr_1_i, we_1_i, be_1_i, wdata_1_i,
    input  mem_douta_i,
    output gnt_0_o, rvalid_0_o, rdata_0_o,
    output gnt_1_o, rvalid_1_o, rdata_1_o,
    output mem_ena_o, mem_wea_o, mem_addra_o, mem_dina_o, mem_regcea_o, mem_rsta_o
  );

  modport master (
    output req_0_i, addr_0_i, we_0_i, be_0_i, wdata_0_i,
    output req_1_i, addr_1_i, we_1_i, be_1_i, wdata_1_i,
    output mem_douta_i,
    input  gnt_0_o, rvalid_0_o, rdata_0_o,
    input  gnt_1_o, rvalid_1_o, rdata_1_o,
    input  mem_ena_o, mem_wea_o, mem_addra_o, mem_dina_o, mem_regcea_o, mem_rsta_o
  );
endinterface

// File: rtl/xil_sp_arbiter.sv
// rtl/xil_sp_arbiter.sv - alternating-priority arbiter sharing one single-port block RAM between two requesters
module xil_sp_arbiter #(
  parameter int NB_COL     = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  xil_sp_arbiter_if.slave  bus
);
  localparam int DW   = NB_COL * COL_WIDTH;
  localparam int LAST = RD_LATENCY - 1;

  typedef enum logic {PRIO0 = 1'b0, PRIO1 = 1'b1} prio_e;

  prio_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         din_q, din_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] own_q, own_d;
  logic                  gnt0, gnt1;
  logic [NB_COL-1:0]     wea;
  logic                  rvalid0, rvalid1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wea     = '0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    vld_d   = '0;
    own_d   = '0;

    // Grants are forced low in reset so nothing reaches the RAM while it is held.
    if (rst_ni) begin
      if (bus.req_0_i && (!bus.req_1_i || state_q == PRIO0)) begin
        gnt0 = 1'b1;
      end else if (bus.req_1_i) begin
        gnt1 = 1'b1;
      end
    end

    if (gnt0) begin
      state_d = PRIO1;
      addr_d  = bus.addr_0_i;
      din_d   = bus.wdata_0_i;
      wea     = bus.be_0_i & {NB_COL{bus.we_0_i}};
    end else if (gnt1) begin
      state_d = PRIO0;
      addr_d  = bus.addr_1_i;
      din_d   = bus.wdata_1_i;
      wea     = bus.be_1_i & {NB_COL{bus.we_1_i}};
    end

    // Ownership pipeline: stage 0 is loaded at acceptance, the last stage lines up with RAM data.
    vld_d[0] = gnt0 | gnt1;
    own_d[0] = gnt1;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PRIO0;
      addr_q  <= '0;
      din_q   <= '0;
      vld_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      vld_q   <= vld_d;
      own_q   <= own_d;
    end
  end

  assign rvalid0 = vld_q[LAST] & ~own_q[LAST];
  assign rvalid1 = vld_q[LAST] &  own_q[LAST];

  assign bus.gnt_0_o    = gnt0;
  assign bus.gnt_1_o    = gnt1;
  assign bus.rvalid_0_o = rvalid0;
  assign bus.rvalid_1_o = rvalid1;
  assign bus.rdata_0_o  = rvalid0 ? bus.mem_douta_i : '0;
  assign bus.rdata_1_o  = rvalid1 ? bus.mem_douta_i : '0;

  // addr_d/din_d already equal the held value when nothing is granted.
  assign bus.mem_ena_o    = gnt0 | gnt1;
  assign bus.mem_wea_o    = wea;
  assign bus.mem_addra_o  = addr_d;
  assign bus.mem_dina_o   = din_d;
  assign bus.mem_regcea_o = (RD_LATENCY == 2) ? vld_q[0] : 1'b0;
  assign bus.mem_rsta_o   = ~rst_ni;
endmodule

// File: tb/tb_xil_sp_arbiter.sv
// tb/tb_xil_sp_arbiter.sv - scoreboard bench for xil_sp_arbiter at read latency 1 and 2
module tb_xil_sp_arbiter;
  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } op_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xil_sp_arbiter_if ifa ();
  xil_sp_arbiter_if ifb ();

  xil_sp_arbiter #(.RD_LATENCY(1)) u_dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
  xil_sp_arbiter #(.RD_LATENCY(2)) u_dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

  logic [31:0] qa0[$], qa1[$], qb0[$], qb1[$];
  int          da0[$], da1[$], db0[$], db1[$];
  logic [10:0] last_addr [2];
  logic [31:0] last_din  [2];

  // RAM models: write-first, inputs captured just before the edge
  logic [31:0] mem_a [0:2047];
  logic [31:0] mem_b [0:2047];
  logic [31:0] w_a, w_b;
  logic [31:0] dout_a = 32'h0, dout_b1 = 32'h0, dout_b2 = 32'h0;
  logic        ca_ena = 1'b0, cb_ena = 1'b0, cb_regce = 1'b0, cb_rst = 1'b0;
  logic [3:0]  ca_wea = 4'h0, cb_wea = 4'h0;
  logic [10:0] ca_addr = 11'h0, cb_addr = 11'h0;
  logic [31:0] ca_din = 32'h0, cb_din = 32'h0;

  always begin
    @(negedge clk);
    #4;
    ca_ena = ifa.mem_ena_o; ca_wea = ifa.mem_wea_o; ca_addr = ifa.mem_addra_o; ca_din = ifa.mem_dina_o;
    cb_ena = ifb.mem_ena_o; cb_wea = ifb.mem_wea_o; cb_addr = ifb.mem_addra_o; cb_din = ifb.mem_dina_o;
    cb_regce = ifb.mem_regcea_o; cb_rst = ifb.mem_rsta_o;
  end

  always @(posedge clk) begin
    if (ca_ena) begin
      w_a = mem_a[ca_addr];
      for (int i = 0; i < 4; i++) if (ca_wea[i]) w_a[8*i +: 8] = ca_din[8*i +: 8];
      mem_a[ca_addr] = w_a;
      dout_a <= w_a;
    end
    if (cb_ena) begin
      w_b = mem_b[cb_addr];
      for (int i = 0; i < 4; i++) if (cb_wea[i]) w_b[8*i +: 8] = cb_din[8*i +: 8];
      mem_b[cb_addr] = w_b;
      dout_b1 <= w_b;
    end
    if (cb_rst) dout_b2 <= 32'h0;
    else if (cb_regce) dout_b2 <= dout_b1;
  end

  assign ifa.mem_douta_i = dout_a;
  assign ifb.mem_douta_i = dout_b2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input logic req, input logic we, input logic [3:0] be,
                             input logic [10:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
    op_t o;
    o.req = req; o.we = we; o.be = be; o.addr = addr; o.wdata = wdata; o.exp = exp;
    return o;
  endfunction

  function automatic op_t nop();
    return mk(1'b0, 1'b0, 4'h0, 11'h0, 32'h0, 32'h0);
  endfunction

  function automatic op_t rd(input logic [10:0] addr, input logic [31:0] exp);
    return mk(1'b1, 1'b0, 4'h0, addr, 32'h0, exp);
  endfunction

  task automatic set_ops(input bit b, input op_t o0, input op_t o1);
    if (!b) begin
      ifa.req_0_i = o0.req; ifa.we_0_i = o0.we; ifa.be_0_i = o0.be; ifa.addr_0_i = o0.addr; ifa.wdata_0_i = o0.wdata;
      ifa.req_1_i = o1.req; ifa.we_1_i = o1.we; ifa.be_1_i = o1.be; ifa.addr_1_i = o1.addr; ifa.wdata_1_i = o1.wdata;
    end else begin
      ifb.req_0_i = o0.req; ifb.we_0_i = o0.we; ifb.be_0_i = o0.be; ifb.addr_0_i = o0.addr; ifb.wdata_0_i = o0.wdata;
      ifb.req_1_i = o1.req; ifb.we_1_i = o1.we; ifb.be_1_i = o1.be; ifb.addr_1_i = o1.addr; ifb.wdata_1_i = o1.wdata;
    end
  endtask

  // One cycle on DUT a (b=0) or b (b=1): drive, check grant and RAM side, queue expected responses.
  task automatic step(input bit b, input op_t o0, input op_t o1, input logic [1:0] eg, input bit push);
    logic [1:0]  g;
    logic        ena;
    logic [3:0]  wea, ew;
    logic [10:0] ad, ea;
    logic [31:0] di, ed;
    string       s;
    set_ops(b, o0, o1);
    set_ops(!b, nop(), nop());
    #1;
    s = b ? "b" : "a";
    if (b) begin
      g = {ifb.gnt_1_o, ifb.gnt_0_o}; ena = ifb.mem_ena_o; wea = ifb.mem_wea_o; ad = ifb.mem_addra_o; di = ifb.mem_dina_o;
    end else begin
      g = {ifa.gnt_1_o, ifa.gnt_0_o}; ena = ifa.mem_ena_o; wea = ifa.mem_wea_o; ad = ifa.mem_addra_o; di = ifa.mem_dina_o;
    end
    if (eg[0]) begin
      ea = o0.addr; ed = o0.wdata; ew = o0.be & {4{o0.we}};
    end else if (eg[1]) begin
      ea = o1.addr; ed = o1.wdata; ew = o1.be & {4{o1.we}};
    end else begin
      ea = last_addr[b]; ed = last_din[b]; ew = 4'h0;
    end
    last_addr[b] = ea;
    last_din[b]  = ed;
    chk({"gnt_", s}, 32'(g), 32'(eg));
    chk({"mem_ena_", s}, 32'(ena), 32'(|eg));
    chk({"mem_wea_", s}, 32'(wea), 32'(ew));
    chk({"mem_addra_", s}, 32'(ad), 32'(ea));
    chk({"mem_dina_", s}, di, ed);
    if (push && eg[0]) begin
      if (b) begin qb0.push_back(o0.exp); db0.push_back(cyc + 2); end
      else   begin qa0.push_back(o0.exp); da0.push_back(cyc + 1); end
    end
    if (push && eg[1]) begin
      if (b) begin qb1.push_back(o1.exp); db1.push_back(cyc + 2); end
      else   begin qa1.push_back(o1.exp); da1.push_back(cyc + 1); end
    end
    @(negedge clk);
  endtask

  // Response monitor: every rvalid must match the oldest queued expectation, on time.
  always @(negedge clk) begin
    chk("rsta_a", 32'(ifa.mem_rsta_o), 32'(!rst_n));
    chk("rsta_b", 32'(ifb.mem_rsta_o), 32'(!rst_n));
    chk("regcea_a", 32'(ifa.mem_regcea_o), 32'h0);
    if (ifa.rvalid_0_o) begin
      chk("rvalid_a0_expected", 32'(qa0.size() > 0), 32'h1);
      if (qa0.size() > 0) begin chk("rdata_a0", ifa.rdata_0_o, qa0.pop_front()); chk("lat_a0", cyc, da0.pop_front()); end
    end else chk("rdata_a0_idle", ifa.rdata_0_o, 32'h0);
    if (ifa.rvalid_1_o) begin
      chk("rvalid_a1_expected", 32'(qa1.size() > 0), 32'h1);
      if (qa1.size() > 0) begin chk("rdata_a1", ifa.rdata_1_o, qa1.pop_front()); chk("lat_a1", cyc, da1.pop_front()); end
    end else chk("rdata_a1_idle", ifa.rdata_1_o, 32'h0);
    if (ifb.rvalid_0_o) begin
      chk("rvalid_b0_expected", 32'(qb0.size() > 0), 32'h1);
      if (qb0.size() > 0) begin chk("rdata_b0", ifb.rdata_0_o, qb0.pop_front()); chk("lat_b0", cyc, db0.pop_front()); end
    end else chk("rdata_b0_idle", ifb.rdata_0_o, 32'h0);
    if (ifb.rvalid_1_o) begin
      chk("rvalid_b1_expected", 32'(qb1.size() > 0), 32'h1);
      if (qb1.size() > 0) begin chk("rdata_b1", ifb.rdata_1_o, qb1.pop_front()); chk("lat_b1", cyc, db1.pop_front()); end
    end else chk("rdata_b1_idle", ifb.rdata_1_o, 32'h0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    last_addr[0] = 11'h0; last_addr[1] = 11'h0;
    last_din[0]  = 32'h0; last_din[1]  = 32'h0;
    set_ops(0, nop(), nop());
    set_ops(1, nop(), nop());
    repeat (2) @(negedge clk);

    // Requests during reset must not be granted
    set_ops(0, mk(1'b1, 1'b1, 4'hF, 11'h7FF, 32'hFFFF_FFFF, 32'h0), rd(11'h7FF, 32'h0));
    #1;
    chk("rst_gnt_a", 32'({ifa.gnt_1_o, ifa.gnt_0_o}), 32'h0);
    chk("rst_ena_a", 32'(ifa.mem_ena_o), 32'h0);
    chk("rst_wea_a", 32'(ifa.mem_wea_o), 32'h0);
    chk("rst_addra_a", 32'(ifa.mem_addra_o), 32'h0);
    chk("rst_dina_a", ifa.mem_dina_o, 32'h0);
    chk("rst_regcea_b", 32'(ifb.mem_regcea_o), 32'h0);
    set_ops(0, nop(), nop());
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Contention from reset: 0,1,0,1,0,1; a losing port holds its request
    for (int k = 0; k < 6; k++) begin
      step(0, mk(1'b1, 1'b1, 4'hF, 11'(32'h100 + (k + 1) / 2), 32'hA000_0000 + 32'((k + 1) / 2), 32'hA000_0000 + 32'((k + 1) / 2)),
              mk(1'b1, 1'b1, 4'hF, 11'(32'h200 + k / 2),       32'hB000_0000 + 32'(k / 2),       32'hB000_0000 + 32'(k / 2)),
           (k % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
    end

    // Single write then read-after-write on port 0
    step(0, mk(1'b1, 1'b1, 4'hF, 11'h010, 32'hDEAD_BEEF, 32'hDEAD_BEEF), nop(), 2'b01, 1'b1);
    step(0, rd(11'h010, 32'hDEAD_BEEF), nop(), 2'b01, 1'b1);

    // Byte enables on port 1
    step(0, nop(), mk(1'b1, 1'b1, 4'hF, 11'h020, 32'h1122_3344, 32'h1122_3344), 2'b10, 1'b1);
    step(0, nop(), mk(1'b1, 1'b1, 4'h5, 11'h020, 32'hAABB_CCDD, 32'h11BB_33DD), 2'b10, 1'b1);
    step(0, nop(), rd(11'h020, 32'h11BB_33DD), 2'b10, 1'b1);

    // Write with no byte enables still responds but changes nothing
    step(0, mk(1'b1, 1'b1, 4'h0, 11'h020, 32'hFFFF_FFFF, 32'h11BB_33DD), nop(), 2'b01, 1'b1);
    step(0, rd(11'h020, 32'h11BB_33DD), nop(), 2'b01, 1'b1);

    // Idle keeps PRIO1 (last grant was port 0)
    repeat (10) step(0, nop(), nop(), 2'b00, 1'b0);
    step(0, rd(11'h010, 32'hDEAD_BEEF), rd(11'h020, 32'h11BB_33DD), 2'b10, 1'b1);
    step(0, rd(11'h010, 32'hDEAD_BEEF), nop(), 2'b01, 1'b1);

    // Latency 2: preload, then back-to-back reads with output-register enable
    for (int k = 1; k <= 3; k++)
      step(1, mk(1'b1, 1'b1, 4'hF, 11'(k), 32'h0101_0101 * 32'(k), 32'h0101_0101 * 32'(k)), nop(), 2'b01, 1'b1);
    repeat (3) step(1, nop(), nop(), 2'b00, 1'b0);
    chk("regcea_b_idle", 32'(ifb.mem_regcea_o), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step(1, rd(11'(k), 32'h0101_0101 * 32'(k)), nop(), 2'b01, 1'b1);
      chk("regcea_b_busy", 32'(ifb.mem_regcea_o), 32'h1);
    end
    step(1, nop(), nop(), 2'b00, 1'b0);
    chk("regcea_b_done", 32'(ifb.mem_regcea_o), 32'h0);
    repeat (3) step(1, nop(), nop(), 2'b00, 1'b0);

    // Reset mid-flight: a accepts on port 1, b accepts on port 0 (moving it to PRIO1)
    set_ops(0, nop(), rd(11'h020, 32'h0));
    set_ops(1, rd(11'h001, 32'h0), nop());
    #1;
    chk("mid_gnt_a", 32'({ifa.gnt_1_o, ifa.gnt_0_o}), 32'h2);
    chk("mid_gnt_b", 32'({ifb.gnt_1_o, ifb.gnt_0_o}), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    set_ops(0, nop(), nop());
    set_ops(1, nop(), nop());
    #1;
    chk("mid_rvalid_a1", 32'(ifa.rvalid_1_o), 32'h0);
    chk("mid_ena_a", 32'(ifa.mem_ena_o), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    last_addr[0] = 11'h0; last_addr[1] = 11'h0;
    last_din[0]  = 32'h0; last_din[1]  = 32'h0;

    // After release both arbiters are back in PRIO0
    step(0, mk(1'b1, 1'b1, 4'hF, 11'h030, 32'h1234_5678, 32'h1234_5678),
            mk(1'b1, 1'b1, 4'hF, 11'h031, 32'h9ABC_DEF0, 32'h9ABC_DEF0), 2'b01, 1'b1);
    step(0, nop(), mk(1'b1, 1'b1, 4'hF, 11'h031, 32'h9ABC_DEF0, 32'h9ABC_DEF0), 2'b10, 1'b1);
    step(1, rd(11'h001, 32'h0101_0101), rd(11'h002, 32'h0202_0202), 2'b01, 1'b1);
    step(1, nop(), rd(11'h002, 32'h0202_0202), 2'b10, 1'b1);
    repeat (4) step(0, nop(), nop(), 2'b00, 1'b0);

    chk("drain_a0", 32'(qa0.size()), 32'h0);
    chk("drain_a1", 32'(qa1.size()), 32'h0);
    chk("drain_b0", 32'(qb0.size()), 32'h0);
    chk("drain_b1", 32'(qb1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
